// File: rtl/spi_frame_sequencer.sv
// spi_frame_sequencer: parses SPI frames (N, N x (din,win), bias) and launches one MAC term per pair.
module spi_frame_sequencer #(
    parameter int MAX_TERMS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_done,
    input  logic [7:0] spi_dout,
    input  logic       cs_n,
    input  logic       mac_busy,
    output logic       mac_start,
    output logic [7:0] mac_din,
    output logic [7:0] mac_win,
    output logic [7:0] mac_bias,
    output logic       acc_clr,
    output logic       frame_done,
    output logic       busy,
    output logic       err_len,
    output logic       err_overrun
);
    typedef enum logic [2:0] {IDLE, GET_DIN, GET_WIN, ISSUE, GET_BIAS, FINISH, ERR} state_t;
    localparam logic [7:0] MAX_N = 8'(MAX_TERMS);
    state_t     state_q;
    logic [7:0] cnt_q, din_q, win_q, mac_din_q, mac_win_q, mac_bias_q;
    logic       mac_start_q, start_prev_q, acc_clr_q, frame_done_q, err_len_q, err_overrun_q;
    logic       can_issue;
    // mac_busy may lag mac_start by a cycle, so it is trusted only two cycles after a launch
    assign can_issue = !mac_busy && !mac_start_q && !start_prev_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= 8'd0;
            din_q         <= 8'd0;
            win_q         <= 8'd0;
            mac_din_q     <= 8'd0;
            mac_win_q     <= 8'd0;
            mac_bias_q    <= 8'd0;
            mac_start_q   <= 1'b0;
            start_prev_q  <= 1'b0;
            acc_clr_q     <= 1'b0;
            frame_done_q  <= 1'b0;
            err_len_q     <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            mac_start_q  <= 1'b0;
            acc_clr_q    <= 1'b0;
            frame_done_q <= 1'b0;
            start_prev_q <= mac_start_q;
            if (cs_n) state_q <= IDLE;
            else case (state_q)
                IDLE: if (spi_done) begin
                    if (spi_dout != 8'd0 && spi_dout <= MAX_N) begin
                        cnt_q     <= spi_dout;
                        acc_clr_q <= 1'b1;
                        state_q   <= GET_DIN;
                    end else begin
                        err_len_q <= 1'b1;
                        state_q   <= ERR;
                    end
                end
                GET_DIN: if (spi_done) begin
                    din_q   <= spi_dout;
                    state_q <= GET_WIN;
                end
                GET_WIN: if (spi_done) begin
                    win_q   <= spi_dout;
                    state_q <= ISSUE;
                end
                ISSUE: begin
                    if (spi_done) err_overrun_q <= 1'b1;
                    if (can_issue) begin
                        mac_din_q   <= din_q;
                        mac_win_q   <= win_q;
                        mac_start_q <= 1'b1;
                        cnt_q       <= cnt_q - 8'd1;
                        state_q     <= (cnt_q == 8'd1) ? GET_BIAS : GET_DIN;
                    end
                end
                GET_BIAS: if (spi_done) begin
                    mac_bias_q <= spi_dout;
                    state_q    <= FINISH;
                end
                FINISH: if (can_issue) begin
                    frame_done_q <= 1'b1;
                    state_q      <= IDLE;
                end
                ERR: state_q <= ERR;
                default: state_q <= IDLE;
            endcase
        end
    end
    assign mac_start   = mac_start_q;
    assign mac_din     = mac_din_q;
    assign mac_win     = mac_win_q;
    assign mac_bias    = mac_bias_q;
    assign acc_clr     = acc_clr_q;
    assign frame_done  = frame_done_q;
    assign busy        = (state_q != IDLE);
    assign err_len     = err_len_q;
    assign err_overrun = err_overrun_q;
endmodule

// File: tb/tb_spi_frame_sequencer.sv
// tb_spi_frame_sequencer: scenario tasks plus randomized frames checked against a frame-level model.
module tb_spi_frame_sequencer;
    localparam int MT = 4;
    logic clk = 0, rst = 1, spi_done = 0, cs_n = 1, busy_force = 0, busy_emu = 0, auto_mac = 0;
    logic [7:0] spi_dout = 8'd0;
    logic mac_busy, mac_start, acc_clr, frame_done, busy, err_len, err_overrun;
    logic [7:0] mac_din, mac_win, mac_bias;
    int checks = 0, errors = 0;
    int n_start = 0, n_clr = 0, n_done = 0;
    logic dbl = 0, p_s = 0, p_c = 0, p_d = 0;
    logic [15:0] st_log [0:1023];

    assign mac_busy = busy_force | busy_emu;

    spi_frame_sequencer #(.MAX_TERMS(MT)) dut (
        .clk(clk), .rst(rst), .spi_done(spi_done), .spi_dout(spi_dout), .cs_n(cs_n),
        .mac_busy(mac_busy), .mac_start(mac_start), .mac_din(mac_din), .mac_win(mac_win),
        .mac_bias(mac_bias), .acc_clr(acc_clr), .frame_done(frame_done), .busy(busy),
        .err_len(err_len), .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mac_start) begin
            st_log[n_start[9:0]] <= {mac_din, mac_win};
            n_start <= n_start + 1;
        end
        if (acc_clr) n_clr <= n_clr + 1;
        if (frame_done) n_done <= n_done + 1;
        if ((mac_start && p_s) || (acc_clr && p_c) || (frame_done && p_d)) dbl <= 1'b1;
        p_s <= mac_start;
        p_c <= acc_clr;
        p_d <= frame_done;
    end

    // MAC emulator: busy raised half a cycle after each launch, held a random 1..4 cycles
    initial forever begin
        @(negedge clk);
        if (auto_mac && mac_start) begin
            busy_emu = 1'b1;
            repeat ($urandom_range(1, 4)) @(negedge clk);
            busy_emu = 1'b0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        spi_dout = b;
        spi_done = 1'b1;
        @(negedge clk);
        spi_done = 1'b0;
    endtask

    task automatic wait_starts(input int target);
        int k = 0;
        while (n_start < target && k < 80) begin
            @(negedge clk); #1;
            k++;
        end
        checks++;
        if (n_start < target) begin errors++; $display("FAIL wait_start got %0d want %0d", n_start, target); end
    endtask

    task automatic wait_done(input int target);
        int k = 0;
        while (n_done < target && k < 80) begin
            @(negedge clk); #1;
            k++;
        end
        checks++;
        if (n_done < target) begin errors++; $display("FAIL wait_done got %0d want %0d", n_done, target); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cs_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({mac_start, acc_clr, frame_done, busy, err_len, err_overrun, mac_din, mac_win, mac_bias} !== 30'd0) begin
            errors++; $display("FAIL reset_outputs got %h want 0",
                {mac_start, acc_clr, frame_done, busy, err_len, err_overrun, mac_din, mac_win, mac_bias});
        end
        @(negedge clk) rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy got %b want 0", busy); end
    endtask

    task automatic test_basic();
        int s0 = n_start, c0 = n_clr, d0 = n_done;
        cs_n = 1'b0;
        send_byte(8'h02);
        send_byte(8'h11);
        send_byte(8'h22);
        checks++;
        if (mac_start !== 1'b0) begin errors++; $display("FAIL basic_early_start got %b want 0", mac_start); end
        @(negedge clk);
        checks++;
        if ({mac_start, mac_din, mac_win} !== {1'b1, 16'h1122}) begin
            errors++; $display("FAIL basic_latency got %h want %h", {mac_start, mac_din, mac_win}, {1'b1, 16'h1122});
        end
        send_byte(8'h33);
        send_byte(8'h44);
        wait_starts(s0 + 2);
        send_byte(8'h55);
        wait_done(d0 + 1);
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (n_clr - c0 !== 1) begin errors++; $display("FAIL basic_acc_clr got %0d want 1", n_clr - c0); end
        checks++;
        if (n_start - s0 !== 2) begin errors++; $display("FAIL basic_starts got %0d want 2", n_start - s0); end
        checks++;
        if (st_log[10'(s0)] !== 16'h1122) begin errors++; $display("FAIL basic_term0 got %h want 1122", st_log[10'(s0)]); end
        checks++;
        if (st_log[10'(s0 + 1)] !== 16'h3344) begin errors++; $display("FAIL basic_term1 got %h want 3344", st_log[10'(s0 + 1)]); end
        checks++;
        if (mac_bias !== 8'h55) begin errors++; $display("FAIL basic_bias got %h want 55", mac_bias); end
        checks++;
        if (n_done - d0 !== 1) begin errors++; $display("FAIL basic_done got %0d want 1", n_done - d0); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle got %b want 0", busy); end
    endtask

    task automatic test_abort();
        int s0 = n_start, d0 = n_done;
        cs_n = 1'b0;
        send_byte(8'h03);
        send_byte(8'h66);
        send_byte(8'h77);
        wait_starts(s0 + 1);
        @(negedge clk) cs_n = 1'b1;
        @(negedge clk) cs_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle got %b want 0", busy); end
        checks++;
        if ({mac_din, mac_win, mac_bias} !== 24'h667755) begin
            errors++; $display("FAIL abort_hold got %h want 667755", {mac_din, mac_win, mac_bias});
        end
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hBB);
        wait_starts(s0 + 2);
        send_byte(8'hCC);
        wait_done(d0 + 1);
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (n_done - d0 !== 1) begin errors++; $display("FAIL abort_done got %0d want 1", n_done - d0); end
        checks++;
        if (st_log[10'(s0 + 1)] !== 16'hAABB) begin errors++; $display("FAIL abort_term got %h want aabb", st_log[10'(s0 + 1)]); end
        checks++;
        if (mac_bias !== 8'hCC) begin errors++; $display("FAIL abort_bias got %h want cc", mac_bias); end
    endtask

    task automatic test_cs_coincident();
        int s0 = n_start;
        cs_n = 1'b0;
        send_byte(8'h01);
        send_byte(8'h12);
        @(negedge clk);
        spi_dout = 8'h34;
        spi_done = 1'b1;
        cs_n = 1'b1;
        @(negedge clk) spi_done = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({busy, err_len, err_overrun} !== 3'b000) begin
            errors++; $display("FAIL coincident_flags got %b want 000", {busy, err_len, err_overrun});
        end
        checks++;
        if (n_start - s0 !== 0) begin errors++; $display("FAIL coincident_start got %0d want 0", n_start - s0); end
        send_byte(8'h00);
        #1;
        checks++;
        if ({busy, err_len} !== 2'b00) begin errors++; $display("FAIL cs_high_idle got %b want 00", {busy, err_len}); end
    endtask

    task automatic test_len_err();
        int s0 = n_start, c0 = n_clr;
        cs_n = 1'b0;
        send_byte(8'h00);
        #1;
        checks++;
        if ({err_len, busy} !== 2'b11) begin errors++; $display("FAIL len_zero got %b want 11", {err_len, busy}); end
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || n_start != s0 || n_clr != c0) begin
            errors++; $display("FAIL len_err_ignore got busy=%b starts=%0d clr=%0d want 1 0 0", busy, n_start - s0, n_clr - c0);
        end
        @(negedge clk) cs_n = 1'b1;
        @(negedge clk) #1;
        checks++;
        if ({busy, err_len} !== 2'b01) begin errors++; $display("FAIL len_exit got %b want 01", {busy, err_len}); end
        cs_n = 1'b0;
        send_byte(8'(MT + 1));
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || n_clr != c0 || n_start != s0) begin
            errors++; $display("FAIL len_over got busy=%b clr=%0d starts=%0d want 1 0 0", busy, n_clr - c0, n_start - s0);
        end
        @(negedge clk) cs_n = 1'b1;
        @(negedge clk) #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL len_over_exit got %b want 0", busy); end
        cs_n = 1'b0;
    endtask

    task automatic test_overrun();
        int s0, d0;
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        #1;
        checks++;
        if ({err_len, err_overrun} !== 2'b00) begin errors++; $display("FAIL rst_clears_flags got %b want 00", {err_len, err_overrun}); end
        s0 = n_start;
        d0 = n_done;
        busy_force = 1'b1;
        cs_n = 1'b0;
        send_byte(8'h01);
        send_byte(8'hA1);
        send_byte(8'hB2);
        send_byte(8'hEE);
        repeat (20) @(negedge clk);
        #1;
        checks++;
        if (n_start - s0 !== 0) begin errors++; $display("FAIL overrun_held got %0d want 0", n_start - s0); end
        checks++;
        if (err_overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag got %b want 1", err_overrun); end
        busy_force = 1'b0;
        wait_starts(s0 + 1);
        send_byte(8'h5C);
        wait_done(d0 + 1);
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (st_log[10'(s0)] !== 16'hA1B2 || n_start - s0 != 1) begin
            errors++; $display("FAIL overrun_term got %h n=%0d want a1b2 n=1", st_log[10'(s0)], n_start - s0);
        end
        checks++;
        if (mac_bias !== 8'h5C) begin errors++; $display("FAIL overrun_bias got %h want 5c", mac_bias); end
    endtask

    task automatic test_rst_midframe();
        int s0 = n_start, d0 = n_done;
        cs_n = 1'b0;
        send_byte(8'h02);
        send_byte(8'h77);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({mac_start, acc_clr, frame_done, busy, err_len, err_overrun, mac_din, mac_win, mac_bias} !== 30'd0) begin
            errors++; $display("FAIL rst_async got %h want 0",
                {mac_start, acc_clr, frame_done, busy, err_len, err_overrun, mac_din, mac_win, mac_bias});
        end
        @(negedge clk) rst = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        checks++;
        if (n_start != s0 || n_done != d0 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_after got starts=%0d done=%0d busy=%b want 0 0 0", n_start - s0, n_done - d0, busy);
        end
    endtask

    task automatic test_random();
        logic [7:0] din_a [MT];
        logic [7:0] win_a [MT];
        logic [7:0] bias;
        int n, s0, c0, d0;
        auto_mac = 1'b1;
        cs_n = 1'b0;
        for (int f = 0; f < 12; f++) begin
            n = (f == 0) ? MT : $urandom_range(1, MT);
            for (int t = 0; t < n; t++) begin
                din_a[t] = 8'($urandom);
                win_a[t] = 8'($urandom);
            end
            bias = 8'($urandom);
            s0 = n_start;
            c0 = n_clr;
            d0 = n_done;
            send_byte(8'(n));
            for (int t = 0; t < n; t++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send_byte(din_a[t]);
                send_byte(win_a[t]);
                wait_starts(s0 + t + 1);
            end
            send_byte(bias);
            wait_done(d0 + 1);
            repeat (2) @(negedge clk);
            #1;
            checks++;
            if (n_start - s0 !== n || n_clr - c0 !== 1 || n_done - d0 !== 1) begin
                errors++; $display("FAIL rand_counts f=%0d got %0d/%0d/%0d want %0d/1/1", f, n_start - s0, n_clr - c0, n_done - d0, n);
            end
            for (int t = 0; t < n; t++) begin
                checks++;
                if (st_log[10'(s0 + t)] !== {din_a[t], win_a[t]}) begin
                    errors++; $display("FAIL rand_term f=%0d t=%0d got %h want %h", f, t, st_log[10'(s0 + t)], {din_a[t], win_a[t]});
                end
            end
            checks++;
            if (mac_bias !== bias) begin errors++; $display("FAIL rand_bias f=%0d got %h want %h", f, mac_bias, bias); end
        end
        auto_mac = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_abort();
        test_cs_coincident();
        test_len_err();
        test_overrun();
        test_rst_midframe();
        test_random();
        #1;
        checks++;
        if (dbl !== 1'b0) begin errors++; $display("FAIL double_pulse got %b want 0", dbl); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
